// File: rtl/arr_check_sched.sv
// ============================================================================
//  Module   : arr_check_sched
//  Brief    : Sequences a compare check across array instances 1..NUM_ARR
//             through an external mux, counting masked sig/rfr mismatches.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module arr_check_sched #(
    parameter int NUM_ARR     = 128,
    parameter int WIDTH       = 128,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode_single,
    input  logic [7:0]       single_idx,
    input  logic             abort,
    input  logic [WIDTH-1:0] cmp_sig,
    input  logic [WIDTH-1:0] cmp_rfr,
    output logic [7:0]       sel,
    output logic             check,
    output logic             busy,
    output logic             done,
    output logic [15:0]      err_count,
    output logic             first_err_valid,
    output logic [7:0]       first_err_idx,
    output logic             range_err,
    output logic             aborted
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SETUP = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [7:0] c_NUM_ARR   = 8'(NUM_ARR);
    localparam logic [3:0] c_HOLD_LAST = 4'(HOLD_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [7:0]       r_sel;
    logic [3:0]       r_hold;
    logic             r_single;
    logic             r_range_bad;
    logic [15:0]      r_err_count;
    logic             r_first_valid;
    logic [7:0]       r_first_idx;
    logic             r_range_err;
    logic             r_aborted;
    logic [WIDTH-1:0] w_mask;
    logic             w_mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An out-of-range single index still spends one SETUP cycle so the
    // done pulse lands at a fixed two cycles after accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) w_next = c_SETUP;
            end
            c_SETUP: begin
                if (abort || r_range_bad)      w_next = c_DONE;
                else if (r_hold == c_HOLD_LAST) w_next = c_CHECK;
            end
            c_CHECK: begin
                if (!abort && !r_single && (r_sel < c_NUM_ARR)) w_next = c_SETUP;
                else                                             w_next = c_DONE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Only bits below the selected index take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask[i] = (i < int'(r_sel));
        end
        w_mismatch = |((cmp_sig ^ cmp_rfr) & w_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel         <= '0;
            r_hold        <= '0;
            r_single      <= 1'b0;
            r_range_bad   <= 1'b0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
            r_range_err   <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_sel         <= mode_single ? single_idx : 8'd1;
                        r_hold        <= '0;
                        r_single      <= mode_single;
                        r_range_bad   <= mode_single &&
                                         ((single_idx == 8'd0) || (single_idx > c_NUM_ARR));
                        r_err_count   <= '0;
                        r_first_valid <= 1'b0;
                        r_first_idx   <= '0;
                        r_range_err   <= 1'b0;
                        r_aborted     <= 1'b0;
                    end
                end
                c_SETUP: begin
                    if (abort || r_range_bad) begin
                        r_sel       <= '0;
                        r_hold      <= '0;
                        r_aborted   <= abort;
                        r_range_err <= r_range_bad;
                    end else if (r_hold == c_HOLD_LAST) begin
                        r_hold <= '0;
                    end else begin
                        r_hold <= r_hold + 4'd1;
                    end
                end
                c_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                        if (!r_first_valid) begin
                            r_first_valid <= 1'b1;
                            r_first_idx   <= r_sel;
                        end
                    end
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_sel     <= '0;
                    end else if (!r_single && (r_sel < c_NUM_ARR)) begin
                        r_sel <= r_sel + 8'd1;
                    end else begin
                        r_sel <= '0;
                    end
                end
                default: begin
                    r_sel <= '0;
                end
            endcase
        end
    end

    assign sel             = r_sel;
    assign check           = (r_state == c_CHECK);
    assign busy            = (r_state == c_SETUP) || (r_state == c_CHECK);
    assign done            = (r_state == c_DONE);
    assign err_count       = r_err_count;
    assign first_err_valid = r_first_valid;
    assign first_err_idx   = r_first_idx;
    assign range_err       = r_range_err;
    assign aborted         = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_arr_check_sched.sv
// ============================================================================
//  Module   : tb_arr_check_sched
//  Brief    : Self-checking bench for arr_check_sched against an index-level
//             reference model of the compare scan.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_arr_check_sched;

    localparam int NUM_ARR     = 128;
    localparam int WIDTH       = 128;
    localparam int HOLD_CYCLES = 2;
    localparam int SCAN_CYC    = NUM_ARR * (HOLD_CYCLES + 1) + 1;
    localparam int WAIT_MAX    = 4000;

    logic             clk = 1'b0;
    logic             reset, start, mode_single, abort;
    logic [7:0]       single_idx;
    logic [WIDTH-1:0] cmp_sig, cmp_rfr;
    logic [7:0]       sel, first_err_idx;
    logic             check, busy, done, first_err_valid, range_err, aborted;
    logic [15:0]      err_count;

    logic [WIDTH-1:0] sig_mem [0:NUM_ARR];
    logic [WIDTH-1:0] rfr_mem [0:NUM_ARR];
    int               check_q[$];
    int               vectors = 0;
    int               miscompares = 0;

    always #5 clk = ~clk;

    arr_check_sched #(
        .NUM_ARR    (NUM_ARR),
        .WIDTH      (WIDTH),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode_single    (mode_single),
        .single_idx     (single_idx),
        .abort          (abort),
        .cmp_sig        (cmp_sig),
        .cmp_rfr        (cmp_rfr),
        .sel            (sel),
        .check          (check),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .first_err_valid(first_err_valid),
        .first_err_idx  (first_err_idx),
        .range_err      (range_err),
        .aborted        (aborted)
    );

    // External mux: presents the selected instance's sig/rfr words.
    always_comb begin
        cmp_sig = '0;
        cmp_rfr = '0;
        if (sel >= 8'd1 && int'(sel) <= NUM_ARR) begin
            cmp_sig = sig_mem[sel];
            cmp_rfr = rfr_mem[sel];
        end
    end

    always @(negedge clk) if (check) check_q.push_back(int'(sel));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_clean();
        for (int i = 0; i <= NUM_ARR; i++) begin
            sig_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            rfr_mem[i] = sig_mem[i];
        end
    endtask

    task automatic flip(input int idx, input int b);
        rfr_mem[idx][b] = ~rfr_mem[idx][b];
    endtask

    // Reference: an index counts as a miss if any bit below it differs.
    task automatic model(input bit ms, input int idx, output int cnt, output int first, output bit rng);
        int               lo, hi;
        logic [WIDTH-1:0] d;
        cnt = 0; first = 0; rng = 1'b0;
        if (ms && (idx < 1 || idx > NUM_ARR)) begin
            rng = 1'b1;
            return;
        end
        lo = ms ? idx : 1;
        hi = ms ? idx : NUM_ARR;
        for (int i = lo; i <= hi; i++) begin
            d = sig_mem[i] ^ rfr_mem[i];
            for (int b = 0; b < i; b++) begin
                if (d[b]) begin
                    cnt++;
                    if (first == 0) first = i;
                    break;
                end
            end
        end
    endtask

    task automatic wait_for(input int s, input bit need_check, input string tag);
        int n = 0;
        while (!(int'(sel) == s && (!need_check || check)) && n < WAIT_MAX) begin
            tick();
            n++;
        end
        chk({tag, "_reached"}, 32'(n < WAIT_MAX), 1);
    endtask

    task automatic run_scan(input bit ms, input int idx, input string tag);
        int cnt, first, n, exp_n;
        bit rng, ok;
        model(ms, idx, cnt, first, rng);
        exp_n = rng ? 2 : (ms ? HOLD_CYCLES + 2 : SCAN_CYC);
        check_q.delete();
        start = 1'b1; mode_single = ms; single_idx = 8'(idx);
        tick();
        start = 1'b0; mode_single = 1'b0;
        n = 1;
        chk({tag, "_busy"}, 32'(busy), 1);
        while (!done && n < SCAN_CYC + 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_n);
        chk({tag, "_busy_done"}, 32'(busy), 0);
        chk({tag, "_sel"}, 32'(sel), 0);
        chk({tag, "_errcnt"}, 32'(err_count), cnt);
        chk({tag, "_fev"}, 32'(first_err_valid), 32'(cnt != 0));
        chk({tag, "_fidx"}, 32'(first_err_idx), first);
        chk({tag, "_range"}, 32'(range_err), 32'(rng));
        chk({tag, "_aborted"}, 32'(aborted), 0);
        ok = (check_q.size() == (rng ? 0 : (ms ? 1 : NUM_ARR)));
        if (ok) foreach (check_q[i]) if (check_q[i] != (ms ? idx : i + 1)) ok = 1'b0;
        chk({tag, "_strobes"}, 32'(ok), 1);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 0);
        chk({tag, "_hold_err"}, 32'(err_count), cnt);
    endtask

    initial begin
        int cnt_q;
        reset = 1'b1; start = 1'b0; mode_single = 1'b0; abort = 1'b0; single_idx = '0;
        fill_clean();
        tick(); tick();
        chk("rst_sel", 32'(sel), 0);
        chk("rst_flags", {23'd0, check, busy, done, first_err_valid, range_err, aborted, 3'd0}, 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_fidx", 32'(first_err_idx), 0);
        reset = 1'b0;
        tick();

        run_scan(1'b0, 0, "clean");

        fill_clean(); flip(5, 2); flip(40, 0);
        run_scan(1'b0, 0, "two_err");

        fill_clean(); flip(3, 7);
        run_scan(1'b0, 0, "above_mask");

        run_scan(1'b1, 0, "single_zero");
        run_scan(1'b1, 200, "single_200");

        for (int r = 0; r < 4; r++) begin
            fill_clean();
            for (int k = 0, n = $urandom_range(0, 6); k < n; k++)
                flip($urandom_range(1, NUM_ARR), $urandom_range(0, WIDTH - 1));
            run_scan(1'b0, 0, "rand_full");
        end
        for (int r = 0; r < 4; r++) begin
            int idx;
            fill_clean();
            idx = $urandom_range(1, NUM_ARR);
            if ($urandom_range(0, 1) == 1) flip(idx, $urandom_range(0, idx + 3));
            run_scan(1'b1, idx, "rand_single");
        end

        // Abort during SETUP; start+abort at accept and a mid-scan start are both harmless.
        fill_clean();
        check_q.delete();
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("abort_start_accept", 32'(busy), 1);
        tick();
        start = 1'b1; mode_single = 1'b1; single_idx = 8'd0; tick();
        start = 1'b0; mode_single = 1'b0;
        wait_for(10, 1'b0, "abort_setup");
        chk("abort_setup_check", 32'(check), 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_setup_done", 32'(done), 1);
        chk("abort_setup_flag", 32'(aborted), 1);
        chk("abort_setup_range", 32'(range_err), 0);
        chk("abort_setup_strobes", check_q.size(), 9);
        tick();
        chk("abort_setup_hold", 32'(aborted), 1);

        // Abort coinciding with CHECK still counts that comparison.
        fill_clean(); flip(7, 0);
        check_q.delete();
        start = 1'b1; tick(); start = 1'b0;
        wait_for(7, 1'b1, "abort_check");
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_check_done", 32'(done), 1);
        chk("abort_check_flag", 32'(aborted), 1);
        chk("abort_check_err", 32'(err_count), 1);
        chk("abort_check_fidx", 32'(first_err_idx), 7);
        chk("abort_check_strobes", check_q.size(), 7);
        tick();

        // Reset mid-scan, with start held alongside to confirm reset priority.
        fill_clean(); flip(10, 0); flip(20, 1); flip(30, 5); flip(100, 3);
        start = 1'b1; tick(); start = 1'b0;
        wait_for(64, 1'b0, "mid_reset");
        cnt_q = int'(err_count);
        chk("mid_reset_err_before", cnt_q, 3);
        reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
        chk("mid_reset_sel", 32'(sel), 0);
        chk("mid_reset_flags", {23'd0, check, busy, done, first_err_valid, range_err, aborted, 3'd0}, 0);
        chk("mid_reset_err", 32'(err_count), 0);
        chk("mid_reset_fidx", 32'(first_err_idx), 0);
        tick();
        chk("mid_reset_idle", 32'(busy), 0);
        run_scan(1'b0, 0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/arr_check_sched.md
ARR_CHECK_SCHED -- requirements
Module: arr_check_sched

Interface
REQ-001 Parameter NUM_ARR, default 128: number of array instances scanned, indexed 1..NUM_ARR; legal range 1..255.
REQ-002 Parameter WIDTH, default 128: width of the compare buses; WIDTH SHALL be >= NUM_ARR.
REQ-003 Parameter HOLD_CYCLES, default 2: settle cycles after each sel change before check; legal range 1..15.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  scan request; sampled only in IDLE.
REQ-008 mode_single  input  1  sampled with start: 1 = check single_idx only; 0 = full scan 1..NUM_ARR.
REQ-009 single_idx  input  8  target index for single mode.
REQ-010 abort  input  1  terminates an active scan.
REQ-011 cmp_sig  input  WIDTH  sig value of the instance selected by sel, from an external mux.
REQ-012 cmp_rfr  input  WIDTH  rfr value of the selected instance.
REQ-013 sel  output  8  currently selected instance index; 0 when idle.
REQ-014 check  output  1  one-cycle strobe to the selected instance's check input.
REQ-015 busy  output  1  high from the cycle after start is accepted until done.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err_count  output  16  mismatch count for the current or last scan; saturates.
REQ-018 first_err_valid / first_err_idx  output  1 / 8  index of the first mismatching instance.
REQ-019 range_err / aborted  output  1 / 1  sticky status for the last scan.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, CHECK and DONE; reset forces IDLE.
REQ-021 IDLE with start=1 at edge T SHALL: clear err_count, first_err_*, range_err and aborted; load sel; enter SETUP at T+1.
REQ-022 Loaded sel SHALL be 1 when mode_single=0, or single_idx when mode_single=1.
REQ-023 When mode_single=1 and single_idx is 0 or >NUM_ARR, the block SHALL enter DONE directly, set range_err=1, and assert no check strobe.
REQ-024 SETUP SHALL hold sel stable for exactly HOLD_CYCLES cycles, then enter CHECK.
REQ-025 CHECK SHALL last one cycle with check=1.
REQ-026 In CHECK, the block SHALL compare cmp_sig against cmp_rfr over bits [sel-1:0] only and ignore all higher bits.
REQ-027 On a mismatch, err_count SHALL increment, saturating at 16'hFFFF.
REQ-028 On the first mismatch of a scan, first_err_idx SHALL load sel and first_err_valid SHALL be set to 1.
REQ-029 After CHECK, a full scan with sel<NUM_ARR SHALL increment sel and return to SETUP; otherwise the block SHALL enter DONE.
REQ-030 DONE SHALL last one cycle with done=1, set sel=0, and return to IDLE; busy SHALL be 0 in DONE.
REQ-031 Timing: each index costs HOLD_CYCLES+1 cycles; a full scan SHALL assert done NUM_ARR*(HOLD_CYCLES+1)+1 cycles after the accept edge.
REQ-032 start SHALL be ignored while not in IDLE, with no restart and no status change.
REQ-033 abort=1 in SETUP or CHECK SHALL enter DONE next cycle and set aborted=1.
REQ-034 If abort coincides with CHECK, check SHALL still be 1 that cycle and the comparison SHALL still be counted.
REQ-035 abort in IDLE SHALL be ignored; abort and start together in IDLE SHALL accept start.
REQ-036 Status outputs SHALL hold their values from DONE until the next accepted start.

Reset
REQ-037 reset=1 at any edge, including mid-scan, SHALL force IDLE and drive sel=0, check=0, busy=0, done=0, err_count=0, first_err_valid=0, first_err_idx=0, range_err=0, aborted=0 from the next cycle.
REQ-038 reset SHALL take priority over start and abort.

Verification
REQ-039 Full scan with NUM_ARR=128, HOLD_CYCLES=2, cmp_sig==cmp_rfr throughout -> check pulses at sel=1..128, done 385 cycles after accept, err_count=0, first_err_valid=0.
REQ-040 Full scan where the mux differs only at sel=5 bit 2 and sel=40 bit 0 -> err_count=2, first_err_idx=5, first_err_valid=1.
REQ-041 Difference only at bit 7 while sel=3 (above the mask) -> no error counted, err_count=0.
REQ-042 Single mode with single_idx=0, then single_idx=200 -> no check strobe, range_err=1, done 2 cycles after accept in each case.
REQ-043 abort asserted during SETUP at sel=10 -> done the next cycle, aborted=1, no check for sel=10; a start issued while busy earlier is ignored.
REQ-044 reset asserted mid-scan at sel=64 with err_count=3 -> all outputs at reset values the next cycle; a new start then performs a clean scan from sel=1.
